// File: rtl/ssp_tx_engine.sv
// SSP master transmit engine: FWFT FIFO pop, TI-style frame pulse, CLK_DIV divider.
// Optional SSP_TX_LSB_FIRST_EN adds a LSB_FIRST input selecting LSB-first shifting.
module ssp_tx_engine #(
  parameter int WORD_SIZE = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic                 PCLK,
  input  logic                 CLEAR,
  input  logic                 TX_ENABLE,
  input  logic [WORD_SIZE-1:0] TxData,
  input  logic                 FIFOEmpty,
`ifdef SSP_TX_LSB_FIRST_EN
  input  logic                 LSB_FIRST,
`endif
  output logic                 read,
  output logic                 SSPCLKOUT,
  output logic                 SSPFSSOUT,
  output logic                 SSPTXD,
  output logic                 SSPOE_B,
  output logic                 BUSY
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW   = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FSS,
    S_SHIFT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 sclk_q;
  logic                 read_q, read_d;
  logic                 fss_q, fss_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic                 rise_tick;
  logic                 more;
  logic                 txbit;

`ifdef SSP_TX_LSB_FIRST_EN
  logic                 lsb_q, lsb_d;
`endif

  assign rise_tick = (cnt_q == CW'(HALF - 1)) && !sclk_q;
  assign more      = !FIFOEmpty && TX_ENABLE;

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (cnt_q == CW'(HALF - 1)) begin
      cnt_q  <= '0;
      sclk_q <= !sclk_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_q  <= S_IDLE;
      read_q   <= 1'b0;
      fss_q    <= 1'b0;
      hold_q   <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
`ifdef SSP_TX_LSB_FIRST_EN
      lsb_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      fss_q    <= fss_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
`ifdef SSP_TX_LSB_FIRST_EN
      lsb_q    <= lsb_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    read_d   = 1'b0;
    fss_d    = fss_q;
    hold_d   = read_q ? TxData : hold_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
`ifdef SSP_TX_LSB_FIRST_EN
    lsb_d    = lsb_q;
`endif
    if (rise_tick) begin
      case (state_q)
        S_IDLE: begin
          if (more) begin
            state_d = S_FSS;
            read_d  = 1'b1;
          end
        end
        S_FSS: begin
          state_d  = S_SHIFT;
          shift_d  = hold_q;
          bitcnt_d = BW'(WORD_SIZE - 1);
`ifdef SSP_TX_LSB_FIRST_EN
          lsb_d    = LSB_FIRST;
`endif
        end
        S_SHIFT: begin
          if (bitcnt_q == '0) begin
            if (fss_q) begin
              // next word already captured: reload without a gap
              fss_d    = 1'b0;
              shift_d  = hold_q;
              bitcnt_d = BW'(WORD_SIZE - 1);
`ifdef SSP_TX_LSB_FIRST_EN
              lsb_d    = LSB_FIRST;
`endif
            end else begin
              state_d = S_IDLE;
            end
          end else begin
`ifdef SSP_TX_LSB_FIRST_EN
            shift_d = lsb_q ? (shift_q >> 1) : (shift_q << 1);
`else
            shift_d = shift_q << 1;
`endif
            bitcnt_d = bitcnt_q - BW'(1);
            if (bitcnt_q == BW'(1)) begin
              fss_d  = more;
              read_d = more;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef SSP_TX_LSB_FIRST_EN
  assign txbit = lsb_q ? shift_q[0] : shift_q[WORD_SIZE-1];
`else
  assign txbit = shift_q[WORD_SIZE-1];
`endif

  assign read      = read_q;
  assign SSPCLKOUT = sclk_q;
  assign SSPTXD    = (state_q == S_SHIFT) && txbit;
  assign SSPOE_B   = (state_q != S_SHIFT);
  assign SSPFSSOUT = (state_q == S_FSS) ||
                     ((state_q == S_SHIFT) && fss_q);
  assign BUSY      = (state_q != S_IDLE);

endmodule
